// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch port and the data port of the MiniMIPS32 core.
//
// Ports:
//   cpu_clk_50M, cpu_rst_n       clock, synchronous active-low reset
//   i_req/i_addr                 fetch request and address
//   i_rdata/i_valid              registered fetch data, one-cycle done pulse
//   d_req/d_we/d_addr/d_wdata    data request (d_we == 0 means load)
//   d_rdata/d_valid              registered load data, one-cycle done pulse
//   stallreq_mem                 stall request while any requester is unserved
//   sram_ce/we/addr/wdata        SRAM command, driven only in the issue cycle
//   sram_rdata                   SRAM read data, RD_LAT cycles after issue

module sram_port_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          cpu_clk_50M,
    input  logic          cpu_rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic [3:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stallreq_mem,
    output logic          sram_ce,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    typedef enum logic {
        IDLE,
        RWAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic       last_grant;
    logic       owner;

    logic       i_elig;
    logic       d_elig;
    logic       grant_d;
    logic       issue;
    logic       d_write;
    logic       capture;

    // A port's own valid cycle consumes its request, so a req that is
    // still high during that cycle must not be granted a second time.
    assign i_elig  = i_req & ~i_valid;
    assign d_elig  = d_req & ~d_valid;

    // Data wins when alone, or on a conflict when I was granted last.
    assign grant_d = d_elig & (~i_elig | ~last_grant);

    // Reset gates the issue so nothing reaches the SRAM while held.
    assign issue   = cpu_rst_n & (state == IDLE) & (i_elig | d_elig);
    assign d_write = grant_d & (d_we != 4'b0000);
    assign capture = (state == RWAIT) & (cnt == 2'd0);

    assign stallreq_mem = cpu_rst_n &
                          ((i_req & ~i_valid) | (d_req & ~d_valid));

    // State register.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Writes complete without leaving IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (issue && !d_write) begin
                    state_nxt = RWAIT;
                end
            end
            RWAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: SRAM command only in the issue cycle.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (issue) begin
            sram_ce    = 1'b1;
            sram_wdata = d_wdata;
            if (grant_d) begin
                sram_we   = d_we;
                sram_addr = d_addr;
            end else begin
                sram_addr = i_addr;
            end
        end
    end

    // Grant history, latency counter and the registered return path.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            cnt        <= 2'd0;
            last_grant <= 1'b0;
            owner      <= 1'b0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;

            if (issue) begin
                last_grant <= grant_d;
                if (d_write) begin
                    d_valid <= 1'b1;
                end else begin
                    cnt   <= CNT_INIT;
                    owner <= grant_d;
                end
            end else if (state == RWAIT && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end

            // Only the owner's buffer is loaded; the other one holds.
            if (capture) begin
                if (owner) begin
                    d_rdata <= sram_rdata;
                    d_valid <= 1'b1;
                end else begin
                    i_rdata <= sram_rdata;
                    i_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench for sram_port_arbiter with one
// instance at RD_LAT=1 (a_*) and one at RD_LAT=3 (b_*), each with an SRAM model.

module tb_sram_port_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        a_i_req, a_i_valid, a_d_req, a_d_valid, a_stall, a_ce;
    logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_d_we, a_we;

    logic        b_i_req, b_i_valid, b_d_req, b_d_valid, b_stall, b_ce;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_d_we, b_we;

    sram_port_arbiter #(.RD_LAT(1), .AW(32), .DW(32)) u_a (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .i_req       (a_i_req),
        .i_addr      (a_i_addr),
        .i_rdata     (a_i_rdata),
        .i_valid     (a_i_valid),
        .d_req       (a_d_req),
        .d_we        (a_d_we),
        .d_addr      (a_d_addr),
        .d_wdata     (a_d_wdata),
        .d_rdata     (a_d_rdata),
        .d_valid     (a_d_valid),
        .stallreq_mem(a_stall),
        .sram_ce     (a_ce),
        .sram_we     (a_we),
        .sram_addr   (a_addr),
        .sram_wdata  (a_wdata),
        .sram_rdata  (a_rdata)
    );

    sram_port_arbiter #(.RD_LAT(3), .AW(32), .DW(32)) u_b (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .i_req       (b_i_req),
        .i_addr      (b_i_addr),
        .i_rdata     (b_i_rdata),
        .i_valid     (b_i_valid),
        .d_req       (b_d_req),
        .d_we        (b_d_we),
        .d_addr      (b_d_addr),
        .d_wdata     (b_d_wdata),
        .d_rdata     (b_d_rdata),
        .d_valid     (b_d_valid),
        .stallreq_mem(b_stall),
        .sram_ce     (b_ce),
        .sram_we     (b_we),
        .sram_addr   (b_addr),
        .sram_wdata  (b_wdata),
        .sram_rdata  (b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents after reset, indexed by addr[5:2].
    function automatic logic [31:0] init_word(int i);
        case (i)
            0:       return 32'h3C08_BFAF;
            1:       return 32'h0000_0000;
            2:       return 32'hDEAD_BEEF;
            3:       return 32'hCAFE_F00D;
            4:       return 32'h0BAD_F00D;
            5:       return 32'h1234_5678;
            8:       return 32'h1111_0008;
            9:       return 32'h2222_0009;
            default: return 32'h0F0F_0000 | 32'(i);
        endcase
    endfunction

    logic [31:0]      mem_a [16];
    logic [31:0]      mem_b [16];
    logic             a_pv;
    logic [31:0]      a_pd;
    logic [2:0]       b_pv;
    logic [2:0][31:0] b_pd;

    // Read data outside the expected return cycle is a poison pattern.
    assign a_rdata = a_pv    ? a_pd    : 32'hA5A5_A5A5;
    assign b_rdata = b_pv[2] ? b_pd[2] : 32'hA5A5_A5A5;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) mem_a[k] <= init_word(k);
            a_pv <= 1'b0;
        end else begin
            if (a_ce && a_we != 4'b0000)
                for (int b = 0; b < 4; b++)
                    if (a_we[b]) mem_a[a_addr[5:2]][8*b +: 8] <= a_wdata[8*b +: 8];
            a_pv <= a_ce && (a_we == 4'b0000);
            a_pd <= mem_a[a_addr[5:2]];
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) mem_b[k] <= init_word(k);
            b_pv <= 3'b000;
        end else begin
            if (b_ce && b_we != 4'b0000)
                for (int b = 0; b < 4; b++)
                    if (b_we[b]) mem_b[b_addr[5:2]][8*b +: 8] <= b_wdata[8*b +: 8];
            b_pv <= {b_pv[1:0], b_ce && (b_we == 4'b0000)};
            b_pd <= {b_pd[1:0], mem_b[b_addr[5:2]]};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_i_req = 1'b1;
        a_d_req = 1'b1;
        b_i_req = 1'b1;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", a_stall); end
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL rst_stall_b got %0h exp 0", b_stall); end
        checks++; if (a_ce !== 1'b0) begin errors++; $display("FAIL rst_ce got %0h exp 0", a_ce); end
        checks++; if ({a_i_valid, a_d_valid} !== 2'b00) begin errors++; $display("FAIL rst_valid got %0b exp 00", {a_i_valid, a_d_valid}); end
        checks++; if (a_i_rdata !== 32'h0) begin errors++; $display("FAIL rst_i_rdata got %0h exp 0", a_i_rdata); end
        checks++; if (a_d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata got %0h exp 0", a_d_rdata); end
        a_i_req = 1'b0;
        a_d_req = 1'b0;
        b_i_req = 1'b0;
        tick;
        rst_n = 1'b1;
        #1;
        checks++; if ({a_ce, a_stall} !== 2'b00) begin errors++; $display("FAIL idle_ce_stall got %0b exp 00", {a_ce, a_stall}); end
    endtask

    task automatic test_fetch;
        tick;
        a_i_req  = 1'b1;
        a_i_addr = 32'hBFC0_0000;
        #1;
        checks++; if (a_ce !== 1'b1) begin errors++; $display("FAIL fetch_ce got %0h exp 1", a_ce); end
        checks++; if (a_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL fetch_addr got %0h exp bfc00000", a_addr); end
        checks++; if (a_we !== 4'h0) begin errors++; $display("FAIL fetch_we got %0h exp 0", a_we); end
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_t got %0h exp 1", a_stall); end
        tick;
        checks++; if ({a_ce, a_stall, a_i_valid} !== 3'b010) begin errors++; $display("FAIL fetch_t1 got %0b exp 010", {a_ce, a_stall, a_i_valid}); end
        tick;
        checks++; if (a_i_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %0h exp 1", a_i_valid); end
        checks++; if (a_i_rdata !== 32'h3C08_BFAF) begin errors++; $display("FAIL fetch_rdata got %0h exp 3c08bfaf", a_i_rdata); end
        checks++; if ({a_stall, a_ce} !== 2'b00) begin errors++; $display("FAIL fetch_t2 got %0b exp 00", {a_stall, a_ce}); end
        a_i_req = 1'b0;
        tick;
        checks++; if (a_i_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %0h exp 0", a_i_valid); end
    endtask

    task automatic test_back_to_back;
        tick;
        a_d_req   = 1'b1;
        a_d_we    = 4'b1111;
        a_d_addr  = 32'h0000_0100;
        a_d_wdata = 32'h1122_3344;
        #1;
        checks++; if ({a_ce, a_we} !== 5'b1_1111) begin errors++; $display("FAIL st1_ce_we got %0h exp 1f", {a_ce, a_we}); end
        checks++; if (a_addr !== 32'h100) begin errors++; $display("FAIL st1_addr got %0h exp 100", a_addr); end
        checks++; if (a_wdata !== 32'h1122_3344) begin errors++; $display("FAIL st1_wdata got %0h exp 11223344", a_wdata); end
        tick;
        a_d_we    = 4'b0011;
        a_d_addr  = 32'h0000_0104;
        a_d_wdata = 32'hAABB_CCDD;
        #1;
        checks++; if ({a_d_valid, a_ce} !== 2'b10) begin errors++; $display("FAIL st1_done got %0b exp 10", {a_d_valid, a_ce}); end
        tick;
        checks++; if ({a_ce, a_we, a_d_valid} !== 6'b1_0011_0) begin errors++; $display("FAIL st2_ce_we got %0b exp 100110", {a_ce, a_we, a_d_valid}); end
        checks++; if (a_addr !== 32'h104) begin errors++; $display("FAIL st2_addr got %0h exp 104", a_addr); end
        checks++; if (a_wdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL st2_wdata got %0h exp aabbccdd", a_wdata); end
        tick;
        a_d_we = 4'b0000;
        #1;
        checks++; if (a_d_valid !== 1'b1) begin errors++; $display("FAIL st2_done got %0h exp 1", a_d_valid); end
        checks++; if (a_d_rdata !== 32'h0) begin errors++; $display("FAIL st_rdata_hold got %0h exp 0", a_d_rdata); end
        tick;
        checks++; if ({a_ce, a_we, a_addr} !== {1'b1, 4'h0, 32'h104}) begin errors++; $display("FAIL ld_issue got %0h exp 1_0_104", {a_ce, a_we, a_addr}); end
        tick;
        tick;
        checks++; if (a_d_valid !== 1'b1) begin errors++; $display("FAIL ld_valid got %0h exp 1", a_d_valid); end
        checks++; if (a_d_rdata !== 32'h0000_CCDD) begin errors++; $display("FAIL ld_merge got %0h exp 0000ccdd", a_d_rdata); end
        a_d_req = 1'b0;
        tick;
    endtask

    task automatic test_both_from_reset;
        rst_n = 1'b0;
        tick;
        a_d_req  = 1'b1;
        a_d_we   = 4'b0000;
        a_d_addr = 32'h8000_0010;
        a_i_req  = 1'b1;
        a_i_addr = 32'h8000_1000;
        #1;
        checks++; if ({a_ce, a_stall} !== 2'b00) begin errors++; $display("FAIL both_in_rst got %0b exp 00", {a_ce, a_stall}); end
        tick;
        rst_n = 1'b1;
        #1;
        checks++; if ({a_ce, a_addr} !== {1'b1, 32'h8000_0010}) begin errors++; $display("FAIL both_c0 got %0h exp 1_80000010", {a_ce, a_addr}); end
        tick;
        checks++; if (a_ce !== 1'b0) begin errors++; $display("FAIL both_c1 got %0h exp 0", a_ce); end
        tick;
        checks++; if ({a_d_valid, a_i_valid} !== 2'b10) begin errors++; $display("FAIL both_c2_valid got %0b exp 10", {a_d_valid, a_i_valid}); end
        checks++; if (a_d_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL both_d_rdata got %0h exp 0badf00d", a_d_rdata); end
        checks++; if ({a_ce, a_addr} !== {1'b1, 32'h8000_1000}) begin errors++; $display("FAIL both_c2_grant got %0h exp 1_80001000", {a_ce, a_addr}); end
        a_d_req = 1'b0;
        tick;
        checks++; if ({a_ce, a_d_valid, a_i_valid} !== 3'b000) begin errors++; $display("FAIL both_c3 got %0b exp 000", {a_ce, a_d_valid, a_i_valid}); end
        tick;
        checks++; if ({a_d_valid, a_i_valid} !== 2'b01) begin errors++; $display("FAIL both_c4_valid got %0b exp 01", {a_d_valid, a_i_valid}); end
        checks++; if (a_i_rdata !== 32'h3C08_BFAF) begin errors++; $display("FAIL both_i_rdata got %0h exp 3c08bfaf", a_i_rdata); end
        a_i_req = 1'b0;
        tick;
    endtask

    task automatic test_alternation;
        logic        exp_ce;
        logic [31:0] exp_addr;
        logic [1:0]  exp_v;
        rst_n = 1'b0;
        tick;
        rst_n    = 1'b1;
        a_d_we   = 4'b0000;
        a_d_addr = 32'h0000_0020;
        a_i_addr = 32'h0000_0024;
        for (int k = 0; k < 20; k++) begin
            a_i_req = ~a_i_valid;
            a_d_req = ~a_d_valid;
            #1;
            exp_ce   = (k % 2 == 0);
            exp_addr = !exp_ce ? 32'h0 : ((k % 4 == 0) ? 32'h20 : 32'h24);
            exp_v    = (k == 0 || exp_ce == 1'b0) ? 2'b00 :
                       ((k % 4 == 2) ? 2'b10 : 2'b01);
            checks++; if ({a_ce, a_addr} !== {exp_ce, exp_addr}) begin errors++; $display("FAIL alt_grant k=%0d got %0h exp %0h", k, {a_ce, a_addr}, {exp_ce, exp_addr}); end
            checks++; if ({a_d_valid, a_i_valid} !== exp_v) begin errors++; $display("FAIL alt_valid k=%0d got %0b exp %0b", k, {a_d_valid, a_i_valid}, exp_v); end
            if (exp_v == 2'b10) begin
                checks++; if (a_d_rdata !== 32'h1111_0008) begin errors++; $display("FAIL alt_d_rdata k=%0d got %0h exp 11110008", k, a_d_rdata); end
            end
            if (exp_v == 2'b01) begin
                checks++; if (a_i_rdata !== 32'h2222_0009) begin errors++; $display("FAIL alt_i_rdata k=%0d got %0h exp 22220009", k, a_i_rdata); end
            end
            tick;
        end
        a_i_req = 1'b0;
        a_d_req = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_rdlat3_load;
        tick;
        b_i_req  = 1'b1;
        b_i_addr = 32'h0000_0014;
        #1;
        checks++; if ({b_ce, b_addr} !== {1'b1, 32'h14}) begin errors++; $display("FAIL l3_i_issue got %0h exp 1_14", {b_ce, b_addr}); end
        for (int k = 1; k < 4; k++) begin
            tick;
            checks++; if ({b_ce, b_i_valid} !== 2'b00) begin errors++; $display("FAIL l3_i_wait t+%0d got %0b exp 00", k, {b_ce, b_i_valid}); end
        end
        tick;
        checks++; if ({b_i_valid, b_i_rdata} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL l3_i_done got %0h exp 1_12345678", {b_i_valid, b_i_rdata}); end
        b_i_req = 1'b0;
        tick;
        b_d_req  = 1'b1;
        b_d_we   = 4'b0000;
        b_d_addr = 32'h0000_0008;
        #1;
        checks++; if ({b_ce, b_we, b_addr} !== {1'b1, 4'h0, 32'h8}) begin errors++; $display("FAIL l3_d_issue got %0h exp 1_0_8", {b_ce, b_we, b_addr}); end
        for (int k = 1; k < 4; k++) begin
            tick;
            checks++; if (b_d_valid !== 1'b0) begin errors++; $display("FAIL l3_d_wait t+%0d got %0h exp 0", k, b_d_valid); end
        end
        tick;
        checks++; if ({b_d_valid, b_d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL l3_d_done got %0h exp 1_deadbeef", {b_d_valid, b_d_rdata}); end
        checks++; if (b_i_rdata !== 32'h1234_5678) begin errors++; $display("FAIL l3_i_hold got %0h exp 12345678", b_i_rdata); end
        b_d_req = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_read;
        tick;
        b_d_req  = 1'b1;
        b_d_we   = 4'b0000;
        b_d_addr = 32'h0000_0008;
        #1;
        checks++; if (b_ce !== 1'b1) begin errors++; $display("FAIL mr_issue got %0h exp 1", b_ce); end
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        checks++; if ({b_ce, b_stall} !== 2'b00) begin errors++; $display("FAIL mr_gate got %0b exp 00", {b_ce, b_stall}); end
        tick;
        b_d_addr = 32'h0000_000C;
        #1;
        checks++; if ({b_ce, b_stall, b_d_valid, b_i_valid} !== 4'b0000) begin errors++; $display("FAIL mr_idle got %0b exp 0000", {b_ce, b_stall, b_d_valid, b_i_valid}); end
        checks++; if ({b_d_rdata, b_i_rdata} !== 64'h0) begin errors++; $display("FAIL mr_rdata got %0h exp 0", {b_d_rdata, b_i_rdata}); end
        tick;
        rst_n = 1'b1;
        #1;
        checks++; if ({b_ce, b_addr, b_d_valid} !== {1'b1, 32'hC, 1'b0}) begin errors++; $display("FAIL mr_reissue got %0h exp 1_c_0", {b_ce, b_addr, b_d_valid}); end
        for (int k = 1; k < 4; k++) begin
            tick;
            checks++; if (b_d_valid !== 1'b0) begin errors++; $display("FAIL mr_no_pulse t+%0d got %0h exp 0", k, b_d_valid); end
        end
        tick;
        checks++; if ({b_d_valid, b_d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL mr_done got %0h exp 1_cafef00d", {b_d_valid, b_d_rdata}); end
        b_d_req = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        a_i_req   = 1'b0;
        a_i_addr  = '0;
        a_d_req   = 1'b0;
        a_d_we    = '0;
        a_d_addr  = '0;
        a_d_wdata = '0;
        b_i_req   = 1'b0;
        b_i_addr  = '0;
        b_d_req   = 1'b0;
        b_d_we    = '0;
        b_d_addr  = '0;
        b_d_wdata = '0;
        repeat (3) tick;
        test_reset;
        test_fetch;
        test_back_to_back;
        test_both_from_reset;
        test_alternation;
        test_rdlat3_load;
        test_reset_mid_read;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
